uart_package_tx: RTL and testbench
==================================

// Module: uart_package_tx
// PURPOSE
//  Serial transmitter for the 35-bit program package consumed by uart_buffer (the receiver).
//  Accepts {data, reg_addr, shape_addr} words over a valid/ready handshake and queues them in a small FIFO.
//  Emits each word as one frame: start bit, 35 data bits LSB-first, stop bit, then enforced idle.
//  Used by the host-side/test harness and by loopback builds to drive the render core's programming link.
// PARAMETERS
//  CLKS_PER_BIT  100  clk cycles per serial bit (f_clk / baud); must match the receiver; >= 2
//  FIFO_DEPTH    4    queued packages; power of 2, >= 2
//  IDLE_BITS     1    extra line-high bit periods after each stop bit, so receiver reaches IDLE; >= 1
// PORTS
//  clk         in   1   system clock; all logic on rising edge
//  rst         in   1   synchronous, active-high reset
//  in_valid    in   1   package present on shape_addr/reg_addr/data
//  in_ready    out  1   FIFO can accept; transfer occurs when in_valid && in_ready at a rising edge
//  shape_addr  in   11  package bits [10:0]
//  reg_addr    in   12  package bits [22:11]
//  data        in   12  package bits [34:23]
//  serial_out  out  1   UART line, idle high; registered output
//  busy        out  1   high while a frame (start..final idle bit) is on the line
//  fifo_count  out  3   packages queued, not counting the frame being sent (width $clog2(FIFO_DEPTH)+1)
// BEHAVIOUR
//  Reset (rst=1 at edge): serial_out=1, busy=0, fifo_count=0, in_ready=1 next cycle; FIFO flushed, counters 0, state IDLE.
//  Reset mid-frame: frame abandoned, line forced high on the next edge; no partial resumption.
//  Handshake: in_ready = !full (combinational from FIFO count only; not dependent on in_valid).
//   When full, push is refused even if a pop occurs the same cycle; the source holds its data.
//   Push and pop in the same cycle when not full/empty: both occur, fifo_count unchanged.
//  Package assembly: pkg[34:0] = {data, reg_addr, shape_addr}; bit i of pkg sent as data bit i.
//  FSM (3-bit state, encodings in shared include):
//   IDLE   : serial_out=1, busy=0. If FIFO non-empty: pop head into shift reg, clk_cnt=0, -> START.
//   START  : serial_out=0 for CLKS_PER_BIT cycles, -> DATA with bit_idx=0.
//   DATA   : serial_out=shift[0] for CLKS_PER_BIT cycles; then shift right, bit_idx++;
//            after bit_idx==34 completes -> STOP.
//   STOP   : serial_out=1 for CLKS_PER_BIT cycles, -> GAP.
//   GAP    : serial_out=1 for IDLE_BITS*CLKS_PER_BIT cycles, -> IDLE.
//  Every bit period is exactly CLKS_PER_BIT clk cycles (clk_cnt 0..CLKS_PER_BIT-1, wrap to 0 on bit change).
//  Frame length = (37 + IDLE_BITS) * CLKS_PER_BIT cycles; default 3800.
//  Latency: word accepted at edge E0 into empty FIFO while IDLE -> popped at E1, serial_out low after E1.
//  Back-to-back: next pop on the IDLE cycle after GAP ends; line high for >= (1+IDLE_BITS) bit periods between frames.
//  busy = (state != IDLE); serial_out and busy are registered, no glitches.
//  Widths: clk_cnt $clog2(CLKS_PER_BIT*IDLE_BITS) bits; bit_idx 6 bits; FIFO pointers wrap modulo FIFO_DEPTH.
//  in_valid with in_ready=0 has no effect; X on data inputs while in_valid=0 is ignored.
// STRUCTURE
//  Shared include uart_package_defs.vh: PACKAGE_SIZE=35, field LSB/width constants
//   (SHAPE_LSB=0/11, REG_LSB=11/12, DATA_LSB=23/12), TX FSM state encodings.
//   uart_buffer adopts the same constants so field mapping cannot diverge.
//  Sub-module uart_package_fifo (synchronous FIFO, WIDTH=35, DEPTH=FIFO_DEPTH, push/pop/full/empty/count).
//  Top holds FSM, bit/clock counters, 35-bit shift register, output register.
// TESTING
//  Bench loops serial_out into uart_buffer (same CLKS_PER_BIT) plus a line monitor.
//  1 Single word shape=0x155 reg=0xABC data=0x123 -> serial_out low 1 cycle after acceptance; receiver
//    program_out pulses once with the same three fields; busy high for exactly 3800 cycles.
//  2 Bit timing: send pkg 35'h5_5555_5555 -> every line transition spaced exactly 100 cycles; start=0, stop=1.
//  3 Burst: hold in_valid for 6 distinct words -> in_ready drops after 5 accepted (4 queued + 1 in flight);
//    all accepted words received in order, none lost or duplicated.
//  4 Simultaneous push/pop at fifo_count=2 -> fifo_count stays 2; order preserved.
//  5 Assert rst at data bit 17 of a frame -> serial_out=1, busy=0, fifo_count=0 next cycle;
//    receiver produces no valid program for that frame after rst clears (ends on start/stop error).
//  6 All-zeros and all-ones packages, CLKS_PER_BIT=4 -> correct decode by receiver, frame = 152 cycles.

Source files
------------

// File: rtl/uart_package_tx_pkg.sv
// Shared constants for the 35-bit program package link: field placement and TX FSM encodings.
// The receiver side uses the same definitions so the field mapping cannot drift.
package uart_package_tx_pkg;

    localparam int unsigned PACKAGE_SIZE = 35;
    localparam int unsigned SHAPE_LSB    = 0;
    localparam int unsigned SHAPE_W      = 11;
    localparam int unsigned REG_LSB      = 11;
    localparam int unsigned REG_W        = 12;
    localparam int unsigned DATA_LSB     = 23;
    localparam int unsigned DATA_W       = 12;
    localparam int unsigned BIT_IDX_W    = 6;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_GAP   = 3'd4
    } tx_state_e;

    function automatic logic [PACKAGE_SIZE-1:0] pack_word(
        input logic [SHAPE_W-1:0] shape_addr,
        input logic [REG_W-1:0]   reg_addr,
        input logic [DATA_W-1:0]  data
    );
        logic [PACKAGE_SIZE-1:0] w;
        w = '0;
        w[SHAPE_LSB +: SHAPE_W] = shape_addr;
        w[REG_LSB   +: REG_W]   = reg_addr;
        w[DATA_LSB  +: DATA_W]  = data;
        return w;
    endfunction

endpackage

// File: rtl/uart_package_fifo.sv
// Small synchronous FIFO holding packages waiting for the serial transmitter.
// A push while full is refused even if a pop happens in the same cycle.
module uart_package_fifo #(
    parameter int unsigned WIDTH = 35,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_package_tx.sv
// UART transmitter for 35-bit program packages: start bit, 35 data bits LSB-first,
// stop bit, then IDLE_BITS of enforced line-high so the receiver settles between frames.
module uart_package_tx
    import uart_package_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 100,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned IDLE_BITS    = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [SHAPE_W-1:0]            shape_addr,
    input  logic [REG_W-1:0]              reg_addr,
    input  logic [DATA_W-1:0]             data,
    output logic                          serial_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT * IDLE_BITS) > 0 ?
                                    $clog2(CLKS_PER_BIT * IDLE_BITS) : 1;

    tx_state_e               state, state_next;
    logic [CNT_W-1:0]        clk_cnt, cnt_next;
    logic [BIT_IDX_W-1:0]    bit_idx, idx_next;
    logic [PACKAGE_SIZE-1:0] shift, shift_next;
    logic [PACKAGE_SIZE-1:0] head;
    logic                    serial_next;
    logic                    pop;
    logic                    full;
    logic                    empty;
    logic                    bit_done;
    logic                    gap_done;

    assign in_ready = !full;

    uart_package_fifo #(
        .WIDTH (PACKAGE_SIZE),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid),
        .pop   (pop),
        .wdata (pack_word(shape_addr, reg_addr, data)),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    assign bit_done = (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign gap_done = (clk_cnt == CNT_W'(CLKS_PER_BIT * IDLE_BITS - 1));

    // Next state, counters, and the line level that the output register will hold next cycle.
    always_comb begin
        state_next  = state;
        cnt_next    = clk_cnt;
        idx_next    = bit_idx;
        shift_next  = shift;
        pop         = 1'b0;
        serial_next = 1'b1;

        case (state)
            ST_IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    shift_next = head;
                    cnt_next   = '0;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    cnt_next   = '0;
                    idx_next   = '0;
                    state_next = ST_DATA;
                end else begin
                    cnt_next = clk_cnt + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    cnt_next   = '0;
                    shift_next = shift >> 1;
                    idx_next   = bit_idx + BIT_IDX_W'(1);
                    if (bit_idx == BIT_IDX_W'(PACKAGE_SIZE - 1)) begin
                        state_next = ST_STOP;
                    end
                end else begin
                    cnt_next = clk_cnt + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    cnt_next   = '0;
                    state_next = ST_GAP;
                end else begin
                    cnt_next = clk_cnt + CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (gap_done) begin
                    cnt_next   = '0;
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = clk_cnt + CNT_W'(1);
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = ST_IDLE;
            end
        endcase

        case (state_next)
            ST_START: serial_next = 1'b0;
            ST_DATA:  serial_next = shift_next[0];
            default:  serial_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            clk_cnt    <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            serial_out <= 1'b1;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            clk_cnt    <= cnt_next;
            bit_idx    <= idx_next;
            shift      <= shift_next;
            serial_out <= serial_next;
            busy       <= (state_next != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_package_tx.sv
// Bench for uart_package_tx: a line monitor decodes every frame off serial_out and
// compares it against a queue of accepted packages in acceptance order.
module tb_uart_package_tx;

    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned IDLE  = 1;
    localparam int unsigned FRAME = (37 + IDLE) * CPB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [10:0] shape_addr = '0;
    logic [11:0] reg_addr = '0;
    logic [11:0] data = '0;
    logic        serial_out;
    logic        busy;
    logic [2:0]  fifo_count;

    int n_checks = 0;
    int n_pass   = 0;
    int rx_count = 0;
    logic [34:0] exp_q [$];

    always #5 clk = ~clk;

    uart_package_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .IDLE_BITS    (IDLE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .shape_addr (shape_addr),
        .reg_addr   (reg_addr),
        .data       (data),
        .serial_out (serial_out),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Offer one package; returns at the accepting edge + 1 time unit.
    task automatic send(input logic [34:0] w);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        {data, reg_addr, shape_addr} = w;
        while (in_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (in_ready === 1'b1) begin
            exp_q.push_back(w);
        end else begin
            check("accept_timeout", 64'(in_ready), 64'd1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        {data, reg_addr, shape_addr} = 35'({$urandom(), $urandom()});
    endtask

    task automatic wait_rx(input int target);
        int n;
        n = 0;
        while (rx_count < target && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("rx_count", 64'(rx_count), 64'(target));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((busy !== 1'b0 || fifo_count !== 3'd0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("reach_idle", 64'(busy), 64'd0);
    endtask

    // Send into an idle transmitter and time the busy window from the first low line cycle.
    task automatic send_and_time(input string tag, input logic [34:0] w);
        int n;
        send(w);
        @(negedge clk);
        @(negedge clk);
        check({tag, "_start_low"}, 64'(serial_out), 64'd0);
        n = 0;
        while (busy === 1'b1 && n < int'(FRAME) + 50) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_busy_len"}, 64'(n), 64'(FRAME));
    endtask

    // Line monitor: samples each bit at its centre and checks edges fall on bit boundaries.
    initial begin : line_monitor
        logic [36:0] bits;
        logic [34:0] expw;
        logic        prev;
        bit          aborted;
        bit          have;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0 || serial_out !== 1'b0) continue;
            bits    = '0;
            prev    = 1'b0;
            aborted = 1'b0;
            have    = 1'b0;
            expw    = '0;
            if (exp_q.size() == 0) begin
                check("unexpected_frame", 64'd1, 64'd0);
            end else begin
                expw = exp_q.pop_front();
                have = 1'b1;
            end
            for (int t = 1; t <= 36 * int'(CPB) + int'(CPB) / 2; t++) begin
                @(negedge clk);
                if (rst !== 1'b0) begin
                    aborted = 1'b1;
                    break;
                end
                if (serial_out !== prev) begin
                    check("edge_align", 64'(t % int'(CPB)), 64'd0);
                    prev = serial_out;
                end
                if (t % int'(CPB) == int'(CPB) / 2) begin
                    bits[t / int'(CPB)] = serial_out;
                end
            end
            if (!aborted) begin
                check("start_bit", 64'(bits[0]), 64'd0);
                check("stop_bit", 64'(bits[36]), 64'd1);
                if (have) begin
                    check("rx_word", 64'(bits[35:1]), 64'(expw));
                end
                rx_count++;
            end
        end
    end

    initial begin : stimulus
        logic [34:0] w;
        int n;
        int rx_base;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_serial", 64'(serial_out), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_count", 64'(fifo_count), 64'd0);
        check("rst_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single word: latency, fields, busy length
        w = {12'h123, 12'hABC, 11'h155};
        send(w);
        @(negedge clk);
        check("t1_count_queued", 64'(fifo_count), 64'd1);
        check("t1_line_still_high", 64'(serial_out), 64'd1);
        @(negedge clk);
        check("t1_start_low", 64'(serial_out), 64'd0);
        check("t1_busy", 64'(busy), 64'd1);
        check("t1_count_popped", 64'(fifo_count), 64'd0);
        n = 0;
        while (busy === 1'b1 && n < int'(FRAME) + 50) begin
            n++;
            @(negedge clk);
        end
        check("t1_busy_len", 64'(n), 64'(FRAME));
        wait_rx(1);

        // Alternating bit pattern; edge alignment checked by the monitor
        wait_idle();
        send_and_time("t2", 35'h5_5555_5555);
        wait_rx(2);

        // Burst of six random words: ready drops after five accepted
        wait_idle();
        rx_base = rx_count;
        for (int i = 0; i < 5; i++) begin
            send(35'({$urandom(), $urandom()}));
        end
        @(negedge clk);
        check("t3_ready_full", 64'(in_ready), 64'd0);
        check("t3_count_full", 64'(fifo_count), 64'd4);
        send(35'({$urandom(), $urandom()}));
        wait_rx(rx_base + 6);

        // Simultaneous push and pop at fifo_count == 2
        wait_idle();
        rx_base = rx_count;
        for (int i = 0; i < 3; i++) begin
            send(35'({$urandom(), $urandom()}));
        end
        @(negedge clk);
        check("t4_count_before", 64'(fifo_count), 64'd2);
        n = 0;
        while (busy !== 1'b0 && n < int'(FRAME) + 50) begin
            @(negedge clk);
            n++;
        end
        check("t4_pop_window", 64'(busy), 64'd0);
        check("t4_ready", 64'(in_ready), 64'd1);
        w = 35'({$urandom(), $urandom()});
        in_valid = 1'b1;
        {data, reg_addr, shape_addr} = w;
        exp_q.push_back(w);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("t4_count_after", 64'(fifo_count), 64'd2);
        check("t4_busy_after", 64'(busy), 64'd1);
        wait_rx(rx_base + 4);

        // Reset during data bit 17 with two words queued
        wait_idle();
        rx_base = rx_count;
        send(35'({$urandom(), $urandom()}));
        @(negedge clk);
        @(negedge clk);
        check("t5_start_low", 64'(serial_out), 64'd0);
        send(35'({$urandom(), $urandom()}));
        send(35'({$urandom(), $urandom()}));
        repeat (72) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t5_rst_serial", 64'(serial_out), 64'd1);
        check("t5_rst_busy", 64'(busy), 64'd0);
        check("t5_rst_count", 64'(fifo_count), 64'd0);
        check("t5_rst_ready", 64'(in_ready), 64'd1);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        check("t5_no_frame", 64'(rx_count), 64'(rx_base));
        check("t5_idle_busy", 64'(busy), 64'd0);

        // All-zeros and all-ones packages
        wait_idle();
        send_and_time("t6_zeros", 35'h0);
        wait_idle();
        send_and_time("t6_ones", 35'h7_FFFF_FFFF);
        wait_rx(rx_base + 2);

        // Random words with random gaps
        wait_idle();
        rx_base = rx_count;
        for (int i = 0; i < 6; i++) begin
            send(35'({$urandom(), $urandom()}));
            repeat ($urandom_range(0, 200)) @(negedge clk);
        end
        wait_rx(rx_base + 6);
        wait_idle();
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
